ram_burst_reader: RTL

- Read-side master for the project's inferred simple-dual-port RAMs (1024x16, synchronous read, 1-cycle latency).
- Accepts a burst command (start address, length) and drives the RAM read port (RA, RClk_En).
- Captures RD and streams words out on a valid/ready interface.
- A 2-entry output buffer absorbs read latency, so throughput is 1 word/cycle under no backpressure, and no word is lost or duplicated when backpressured.

---
 rtl/ram_burst_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Burst read master for the 1024x16 simple-dual-port RAMs.
// Streams a command's words out over valid/ready through a 2-entry buffer.
module ram_burst_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 11
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              CMD_Valid,
    output logic              CMD_Ready,
    input  logic [ADDR_W-1:0] CMD_Addr,
    input  logic [LEN_W-1:0]  CMD_Len,
    output logic [ADDR_W-1:0] RA,
    output logic              RClk_En,
    input  logic [DATA_W-1:0] RD,
    output logic              OUT_Valid,
    input  logic              OUT_Ready,
    output logic [DATA_W-1:0] OUT_Data,
    output logic              OUT_Last,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

    state_t state_q, state_d;

    logic [ADDR_W-1:0]         addr_q;
    logic [LEN_W-1:0]          rem_q;
    logic                      inflight_q;
    logic                      infl_last_q;
    logic                      zdone_q;
    logic [1:0][DATA_W-1:0]    buf_data;
    logic [1:0]                buf_last;
    logic [1:0]                occ_q;
    logic                      head_q;

    logic [LEN_W-1:0] len_eff;
    logic             accept;
    logic             pop;
    logic             issue;
    logic             fin;
    logic             wr_idx;

    assign len_eff   = (CMD_Len > DEPTH) ? DEPTH : CMD_Len;
    assign OUT_Valid = (occ_q != 2'd0);
    assign OUT_Data  = buf_data[head_q];
    assign OUT_Last  = OUT_Valid & buf_last[head_q];
    assign pop       = OUT_Valid & OUT_Ready;
    assign accept    = (state_q == IDLE) & CMD_Valid;
    assign RA        = addr_q;
    // Tail slot sits one past the head when a word is already buffered.
    assign wr_idx    = head_q ^ occ_q[0];
    assign fin       = (state_q == DRAIN) & ~inflight_q & (occ_q == 2'd0);

    // Outstanding words after this cycle must never exceed two.
    assign issue = (state_q == RUN) && (rem_q != '0) &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) <
                    (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d   = state_q;
        CMD_Ready = 1'b0;
        Busy      = 1'b0;
        RClk_En   = 1'b0;
        Done      = zdone_q;
        unique case (state_q)
            IDLE: begin
                CMD_Ready = 1'b1;
                if (accept && len_eff != '0) state_d = RUN;
            end
            RUN: begin
                Busy    = 1'b1;
                RClk_En = issue;
                if (issue && rem_q == ONE) state_d = DRAIN;
            end
            DRAIN: begin
                Busy = 1'b1;
                if (fin) begin
                    Done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            zdone_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= CMD_Addr;
                rem_q  <= len_eff;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - ONE;
            end
            inflight_q  <= issue;
            infl_last_q <= issue && (rem_q == ONE);
            zdone_q     <= accept && (len_eff == '0);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            buf_data <= '0;
            buf_last <= '0;
            occ_q    <= 2'd0;
            head_q   <= 1'b0;
        end else begin
            if (inflight_q) begin
                buf_data[wr_idx] <= RD;
                buf_last[wr_idx] <= infl_last_q;
            end
            if (pop) head_q <= ~head_q;
            unique case ({inflight_q, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule
